// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/shift ops, bit-serial MULU and DIVU.
// Define ITER_ALU_DIV_EN to build the restoring divider; otherwise cmd 10 is undefined.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] fast_res;
  logic [WIDTH-1:0] fast_hi;
  logic             fast_ovf;
  logic             fast_dbz;
  logic             needs_iter;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [SH_W-1:0]  shamt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign in_ready = (state_reg == IDLE);

  // Single-cycle results are computed straight from the request and registered on accept.
  always_comb begin
    fast_res   = '0;
    fast_hi    = '0;
    fast_ovf   = 1'b0;
    fast_dbz   = 1'b0;
    needs_iter = 1'b0;
    sum_ext    = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    dif_ext    = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    shamt      = b[SH_W-1:0];
    case (cmd)
      4'd0: fast_res = a & b;
      4'd1: fast_res = a | b;
      4'd2: begin
        fast_res = sum_ext[WIDTH-1:0];
        fast_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
      end
      4'd3: begin
        fast_res = dif_ext[WIDTH-1:0];
        fast_ovf = dif_ext[WIDTH] ^ dif_ext[WIDTH-1];
      end
      4'd4: fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd5: fast_res = ~(a | b);
      4'd6: fast_res = a << shamt;
      4'd7: fast_res = a >> shamt;
      4'd8: fast_res = $unsigned($signed(a) >>> shamt);
      4'd9: needs_iter = 1'b1;
`ifdef ITER_ALU_DIV_EN
      4'd10: begin
        if (b == '0) begin
          fast_res = '1;
          fast_hi  = a;
          fast_dbz = 1'b1;
        end else begin
          needs_iter = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
  assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});

`ifdef ITER_ALU_DIV_EN
  logic             op_div_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_reg});

  always_comb begin
    if (op_div_reg) begin
      step_hi = div_ge ? WIDTH'(div_shift - {1'b0, b_reg}) : div_shift[WIDTH-1:0];
      step_lo = {lo_reg[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_div_reg <= 1'b0;
      b_reg      <= '0;
    end else if (state_reg == IDLE && in_valid) begin
      op_div_reg <= (cmd == 4'd10);
      b_reg      <= b;
    end
  end
`else
  assign step_hi = mul_sum[WIDTH:1];
  assign step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      a_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            cnt_reg <= '0;
            a_reg   <= a;
            hi_reg  <= '0;
            if (needs_iter) begin
              lo_reg    <= (cmd == 4'd10) ? a : b;
              state_reg <= ITER;
            end else begin
              result      <= fast_res;
              result_hi   <= fast_hi;
              overflow    <= fast_ovf;
              zero        <= (fast_res == '0);
              div_by_zero <= fast_dbz;
              out_valid   <= 1'b1;
              state_reg   <= DONE;
            end
          end
        end
        ITER: begin
          hi_reg <= step_hi;
          lo_reg <= step_lo;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            cnt_reg     <= '0;
            result      <= step_lo;
            result_hi   <= step_hi;
            overflow    <= 1'b0;
            zero        <= (step_lo == '0);
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
